seg_frame_scheduler: RTL
========================

Name: seg_frame_scheduler

Overview:
- Arbitrates the four-digit 7-segment display between game-phase requesters: bet (0), dealer (1), player hand 1 (2), split hand 2 (3).
- Each requester presents a complete 16-bit frame of four 4-bit digit codes.
- The scheduler latches one frame at a time and holds it for a minimum dwell time. It then hands the display to the next requester in round-robin order.
- Sits between the game top level and the anode-scan/segment-decode stage, which consumes disp_frame.

Parameters:
- HOLD_CYCLES, 50000000, minimum clock cycles a granted frame stays on the display (0.5 s at 100 MHz); legal range 1..2^32-1.
- CNT_W, 32, width of the dwell counter; must hold HOLD_CYCLES-1.

Ports:
- clk  in  1  100 MHz system clock.
- reset  in  1  asynchronous, active-low reset.
- req  in  4  req[i]=1: requester i has a frame to show; held until ack[i].
- frame_bus  in  64  frame of requester i at bits [16i+15:16i]; each frame is {digit3, digit2, digit1, digit0}, 4-bit codes; digit3 is the leftmost digit.
- flush  in  1  synchronous abort; blanks the display and discards the current hold.
- ack  out  4  one-cycle pulse on the edge that latches requester i's frame.
- disp_frame  out  16  frame currently driven to the scan stage.
- disp_src  out  2  index of the requester owning disp_frame.
- disp_valid  out  1  1 while a granted frame is displayed.
- hold_done  out  1  1 when the dwell has expired and a new grant is allowed.

Behaviour:
- Digit codes:
  - 0x0-0x9 are decimal digits.
  - 0xA is "b", 0xB is "d", 0xC is "A", 0xD is blank.
  - 0xE and 0xF are illegal. Each illegal nibble is replaced by 0xD when latched; legal nibbles pass unchanged.
- Reset (reset=0, asynchronous):
  - state=IDLE, disp_frame=16'hDDDD, disp_src=0, disp_valid=0, ack=0, hold_done=0, dwell counter=0.
  - Round-robin pointer last=3, so requester 0 has first priority.
- States: IDLE and SHOW.
  - IDLE: no frame owned. hold_done=0.
  - SHOW: a frame is owned. hold_done=1 iff counter==0.
- Grant condition: (state==IDLE or hold_done==1) and req!=0 and flush==0.
- Winner: the first i with req[i]=1, searching last+1, last+2, ... modulo 4.
- Grant edge (all registered on the same edge):
  - disp_frame <= sanitised frame of the winner.
  - disp_src <= winner; last <= winner.
  - ack[winner] <= 1 for exactly one cycle.
  - counter <= HOLD_CYCLES-1; state <= SHOW; disp_valid <= 1.
- Latency: req seen in an eligible cycle -> frame and ack visible on the next edge (1 cycle).
- Dwell:
  - In SHOW the counter decrements by 1 per cycle and saturates at 0.
  - The new frame is visible for at least HOLD_CYCLES cycles before the next grant.
  - HOLD_CYCLES=1 gives back-to-back grants every cycle.
- Expired dwell with no request: stay in SHOW, keep the frame, hold_done stays 1. The next request is granted on the first edge at which it is seen.
- Same requester re-requesting: allowed, and granted again if it is the only requester. It loses to any other pending requester.
- req dropped before ack: no grant, no error. req is sampled only in eligible cycles.
- frame_bus is sampled only on the grant edge; changes at other times have no effect.
- flush=1 (overrides any grant in the same cycle):
  - next edge: state=IDLE, disp_frame=16'hDDDD, disp_valid=0, ack=0, counter=0.
  - disp_src and last are unchanged.
- Reset asserted mid-hold: immediate return to reset values, including ack forced to 0.

Test Plan:
- HOLD_CYCLES=4. Release reset; req=4'b0001, frame0=16'hA0D5 -> 1 cycle later ack=4'b0001 pulse, disp_frame=A0D5, disp_src=0, disp_valid=1; hold_done=1 exactly 3 cycles after the grant edge.
- HOLD_CYCLES=4. req=4'b1111 held continuously, each requester dropping its req after its ack -> grants in order 0,1,2,3, spaced exactly 4 cycles apart; each ack lasts exactly 1 cycle.
- Frame 16'hEF12 from requester 2 -> disp_frame=16'hDD12.
- In SHOW with counter=2, assert flush for 1 cycle while req=4'b0010 -> next edge disp_frame=DDDD, disp_valid=0, no ack; grant to requester 1 on the following edge.
- After a grant to requester 3, assert reset=0 asynchronously mid-cycle -> outputs reach reset values immediately without waiting for a clock edge; after release, req=4'b1000 is granted.
- HOLD_CYCLES=1, only req[2]=1 held continuously -> ack[2]=1 on every cycle after the first grant; disp_src stays 2.

Source files
------------

// File: rtl/seg_frame_scheduler.sv
// Round-robin owner of the four-digit 7-segment display: latches one requester's frame,
// holds it for a minimum dwell, then hands the display on to the next pending requester.
module seg_frame_scheduler #(
  parameter int unsigned HOLD_CYCLES = 50000000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [63:0] frame_bus,
  input  logic        flush,
  output logic [3:0]  ack,
  output logic [15:0] disp_frame,
  output logic [1:0]  disp_src,
  output logic        disp_valid,
  output logic        hold_done
);

  typedef enum logic [0:0] {StIdle, StShow} state_e;

  localparam logic [15:0]      BlankFrame = 16'hDDDD;
  localparam logic [CNT_W-1:0] HoldLoad   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne     = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      frame_q, frame_d;
  logic [1:0]       src_q, src_d;
  logic [1:0]       last_q, last_d;
  logic             valid_q, valid_d;
  logic [3:0]       ack_q, ack_d;

  logic             win_found;
  logic [1:0]       win_idx;
  logic             grant;

  // Codes 0xE/0xF have no glyph; show them as blank rather than garbage.
  function automatic logic [15:0] sanitise(input logic [15:0] f);
    logic [15:0] s;
    s = f;
    for (int n = 0; n < 4; n++) begin
      if (f[4*n +: 4] > 4'hD) begin
        s[4*n +: 4] = 4'hD;
      end
    end
    return s;
  endfunction

  // Search starts just after the last owner, so the previous winner ranks lowest.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_q;
    for (int k = 1; k <= 4; k++) begin
      if (!win_found && req[last_q + 2'(k)]) begin
        win_found = 1'b1;
        win_idx   = last_q + 2'(k);
      end
    end
  end

  assign hold_done = (state_q == StShow) && (cnt_q == '0);
  assign grant     = ((state_q == StIdle) || hold_done) && win_found && !flush;

  always_comb begin
    state_d = state_q;
    cnt_d   = ((state_q == StShow) && (cnt_q != '0)) ? cnt_q - CntOne : cnt_q;
    frame_d = frame_q;
    src_d   = src_q;
    last_d  = last_q;
    valid_d = valid_q;
    ack_d   = '0;

    if (flush) begin
      state_d = StIdle;
      frame_d = BlankFrame;
      valid_d = 1'b0;
      cnt_d   = '0;
    end else if (grant) begin
      state_d        = StShow;
      frame_d        = sanitise(frame_bus[{win_idx, 4'b0000} +: 16]);
      src_d          = win_idx;
      last_d         = win_idx;
      valid_d        = 1'b1;
      cnt_d          = HoldLoad;
      ack_d[win_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      frame_q <= BlankFrame;
      src_q   <= 2'd0;
      last_q  <= 2'd3;
      valid_q <= 1'b0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      src_q   <= src_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
    end
  end

  assign ack        = ack_q;
  assign disp_frame = frame_q;
  assign disp_src   = src_q;
  assign disp_valid = valid_q;

endmodule
